// File: rtl/top_k_pkg.sv
// Shared definitions for the top-k result serializer: lane geometry,
// FSM state encoding, and header word field positions.
// Optional build macro: TOP_K_SER_HEADER_EN (prepends a header word per beat).
package top_k_pkg;

    localparam int TOP_K_LANES  = 16;
    localparam int INTEGER_SIZE = 32;

    // Header word layout: captured mask in the upper half, enabled-lane count low.
    localparam int HDR_MASK_LSB = 16;
    localparam int HDR_MASK_MSB = 31;
    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_CNT_MSB  = 4;
    localparam int HDR_CNT_W    = HDR_CNT_MSB - HDR_CNT_LSB + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Number of enabled lanes in a mask; 16 lanes fit in the 5-bit count field.
    function automatic logic [HDR_CNT_W-1:0] lane_count(input logic [TOP_K_LANES-1:0] m);
        logic [HDR_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < TOP_K_LANES; i++) begin
            cnt = cnt + HDR_CNT_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/top_k_lane_picker.sv
// Combinational priority encoder: lowest set mask bit at or above 'start'.
// 'start' is one bit wider than the index so a walk that has passed the top
// lane (start == LANES) reports none-left instead of wrapping to lane 0.
module top_k_lane_picker
    import top_k_pkg::*;
#(
    parameter int LANES = TOP_K_LANES
) (
    input  logic [LANES-1:0]         mask,
    input  logic [$clog2(LANES):0]   start,
    output logic [$clog2(LANES)-1:0] idx,
    output logic                     none
);

    localparam int IDX_W   = $clog2(LANES);
    localparam int START_W = IDX_W + 1;

    // Scan downward so the lowest qualifying lane is the last one written.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (START_W'(i) >= start)) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/top_k_result_serializer.sv
// Top-k result serializer: accepts one wide beat of TOP_K_NUM+1 lanes plus an
// enable mask, then streams the enabled lanes in ascending order on a narrow
// AXI-Stream style output, TLAST on the final word.
// Optional build macro: TOP_K_SER_HEADER_EN (prepends a mask/count header word).
module top_k_result_serializer #(
    parameter int TOP_K_NUM    = 15,
    parameter int INTEGER_SIZE = top_k_pkg::INTEGER_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rx_data_TVALID,
    output logic                                  rx_data_TREADY,
    input  logic [(TOP_K_NUM+1)*INTEGER_SIZE-1:0] rx_data_TDATA,
    input  logic [TOP_K_NUM:0]                    enable_register,
    output logic                                  tx_data_TVALID,
    input  logic                                  tx_data_TREADY,
    output logic [INTEGER_SIZE-1:0]               tx_data_TDATA,
    output logic                                  tx_data_TLAST,
    output logic                                  drop_pulse
);

    import top_k_pkg::*;

    localparam int LANES   = TOP_K_NUM + 1;
    localparam int IDX_W   = $clog2(LANES);
    localparam int START_W = IDX_W + 1;
    localparam int BEAT_W  = LANES * INTEGER_SIZE;

    state_t                    state_q,    state_d;
    logic                      ready_q,    ready_d;
    logic [LANES-1:0]          mask_q,     mask_d;
    logic [BEAT_W-1:0]         data_q,     data_d;
    logic [START_W-1:0]        start_q,    start_d;
    logic                      tx_valid_q, tx_valid_d;
    logic [INTEGER_SIZE-1:0]   tx_data_q,  tx_data_d;
    logic                      tx_last_q,  tx_last_d;
    logic                      drop_q,     drop_d;

    logic                      capture;
    logic [LANES-1:0]          mask_sel;
    logic [BEAT_W-1:0]         data_sel;
    logic [START_W-1:0]        start_sel;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_none;
    logic [INTEGER_SIZE-1:0]   pick_word;
    logic                      pick_last;
    logic [START_W-1:0]        pick_next;

`ifdef TOP_K_SER_HEADER_EN
    function automatic logic [INTEGER_SIZE-1:0] header_word(input logic [LANES-1:0] m);
        logic [INTEGER_SIZE-1:0] hdr;
        hdr = '0;
        hdr[HDR_MASK_MSB:HDR_MASK_LSB] = TOP_K_LANES'(m);
        hdr[HDR_CNT_MSB:HDR_CNT_LSB]   = lane_count(TOP_K_LANES'(m));
        return hdr;
    endfunction
`endif

    assign capture = ready_q && rx_data_TVALID;

    // On a capture cycle the first lane is chosen straight from the input beat,
    // which is what gives the one-cycle capture-to-first-word latency.
    assign mask_sel  = capture ? enable_register : mask_q;
    assign data_sel  = capture ? rx_data_TDATA   : data_q;
    assign start_sel = capture ? '0              : start_q;

    top_k_lane_picker #(
        .LANES (LANES)
    ) u_picker (
        .mask  (mask_sel),
        .start (start_sel),
        .idx   (pick_idx),
        .none  (pick_none)
    );

    // Word of the picked lane, whether it is the highest enabled one, and where
    // the walk resumes (idx+1 in a wider field, so lane 15 ends without wrap).
    always_comb begin
        pick_word = data_sel[pick_idx*INTEGER_SIZE +: INTEGER_SIZE];
        pick_last = ((mask_sel >> pick_idx) == {{(LANES-1){1'b0}}, 1'b1});
        pick_next = START_W'(pick_idx) + START_W'(1);
    end

    // Next-state and registered-output logic for the IDLE/SEND serializer.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        mask_d     = mask_q;
        data_d     = data_q;
        start_d    = start_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        drop_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (capture) begin
                    mask_d = enable_register;
                    data_d = rx_data_TDATA;
`ifdef TOP_K_SER_HEADER_EN
                    state_d    = ST_SEND;
                    ready_d    = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = header_word(enable_register);
                    tx_last_d  = (enable_register == '0);
                    start_d    = '0;
`else
                    if (pick_none) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d    = ST_SEND;
                        ready_d    = 1'b0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = pick_word;
                        tx_last_d  = pick_last;
                        start_d    = pick_next;
                    end
`endif
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_data_TREADY) begin
                    if (tx_last_q || pick_none) begin
                        state_d    = ST_IDLE;
                        ready_d    = 1'b1;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                    end else begin
                        tx_data_d = pick_word;
                        tx_last_d = pick_last;
                        start_d   = pick_next;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ready_d    = 1'b0;
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            mask_q     <= '0;
            data_q     <= '0;
            start_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            start_q    <= start_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            drop_q     <= drop_d;
        end
    end

    assign rx_data_TREADY = ready_q;
    assign tx_data_TVALID = tx_valid_q;
    assign tx_data_TDATA  = tx_data_q;
    assign tx_data_TLAST  = tx_last_q;
    assign drop_pulse     = drop_q;

endmodule

// File: tb/tb_top_k_result_serializer.sv
// Self-checking bench for top_k_result_serializer: directed beats plus
// randomized masks/data/backpressure compared against a lane-list model.
// Honours TOP_K_SER_HEADER_EN the same way as the design.
module tb_top_k_result_serializer;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic          rx_ready;
    logic [511:0]  rx_data;
    logic [15:0]   enable;
    logic          tx_valid;
    logic          tx_ready;
    logic [31:0]   tx_data;
    logic          tx_last;
    logic          drop;

    int n_checks = 0;
    int n_errors = 0;

    top_k_result_serializer #(
        .TOP_K_NUM    (15),
        .INTEGER_SIZE (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_TVALID  (rx_valid),
        .rx_data_TREADY  (rx_ready),
        .rx_data_TDATA   (rx_data),
        .enable_register (enable),
        .tx_data_TVALID  (tx_valid),
        .tx_data_TREADY  (tx_ready),
        .tx_data_TDATA   (tx_data),
        .tx_data_TLAST   (tx_last),
        .drop_pulse      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_beat();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Sends one beat and checks the whole output stream against the model:
    // expected words are the enabled lanes in ascending order, last flagged.
    // mode: 0 = ready high, 1 = ready toggling, 2 = random ready,
    //       3 = ready high with enable forced to 16'h0001 after capture.
    task automatic run_beat(input logic [15:0] mask, input logic [511:0] data, input int mode);
        logic [32:0] exp_q[$];
        int          guard;
        bit          rdy;
        logic [31:0] hdr;
        hdr = {mask, 11'b0, 5'($countones(mask))};
`ifdef TOP_K_SER_HEADER_EN
        exp_q.push_back({1'b0, hdr});
`endif
        for (int i = 0; i < 16; i++)
            if (mask[i]) exp_q.push_back({1'b0, data[32*i +: 32]});
        if (exp_q.size() > 0) exp_q[exp_q.size()-1][32] = 1'b1;

        guard = 0;
        while (rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("rx_ready_before_beat", 64'(rx_ready), 64'd1);

        rx_valid = 1'b1;
        rx_data  = data;
        enable   = mask;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = rand_beat();
        enable   = (mode == 3) ? 16'h0001 : 16'($urandom);

        if (exp_q.size() == 0) begin
            check_val("drop_pulse_set", 64'(drop), 64'd1);
            check_val("drop_no_tx", 64'(tx_valid), 64'd0);
            @(negedge clk);
            check_val("drop_pulse_clear", 64'(drop), 64'd0);
            check_val("drop_no_tx_after", 64'(tx_valid), 64'd0);
            check_val("drop_ready", 64'(rx_ready), 64'd1);
            return;
        end

        check_val("no_drop", 64'(drop), 64'd0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            check_val("tx_valid", 64'(tx_valid), 64'd1);
            check_val("tx_data", 64'(tx_data), 64'(exp_q[0][31:0]));
            check_val("tx_last", 64'(tx_last), 64'(exp_q[0][32]));
            check_val("rx_ready_busy", 64'(rx_ready), 64'd0);
            case (mode)
                1:       rdy = (guard % 2) == 0;
                2:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = 1'b1;
            endcase
            tx_ready = rdy;
            @(negedge clk);
            if (rdy) void'(exp_q.pop_front());
            guard++;
        end
        tx_ready = 1'b1;
        check_val("beat_words_left", 64'(exp_q.size()), 64'd0);
        check_val("idle_tx_valid", 64'(tx_valid), 64'd0);
        check_val("idle_tx_last", 64'(tx_last), 64'd0);
        check_val("idle_rx_ready", 64'(rx_ready), 64'd1);
    endtask

    initial begin
        logic [511:0] beat;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        enable   = '0;
        tx_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_val("rst_tx_last", 64'(tx_last), 64'd0);
        check_val("rst_tx_data", 64'(tx_data), 64'd0);
        check_val("rst_drop", 64'(drop), 64'd0);
        check_val("rst_rx_ready", 64'(rx_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("rx_ready_before_edge", 64'(rx_ready), 64'd0);
        @(negedge clk);
        check_val("rx_ready_after_rst", 64'(rx_ready), 64'd1);

        // All lanes, values 1..16
        for (int i = 0; i < 16; i++) beat[32*i +: 32] = 32'(i + 1);
        run_beat(16'hFFFF, beat, 0);

        // Sparse mask, lane 15 terminates
        run_beat(16'h8421, rand_beat(), 0);
        // Empty mask
        run_beat(16'h0000, rand_beat(), 0);
        // Stalls on alternate cycles
        run_beat(16'h00F0, rand_beat(), 1);
        // Single lanes at both ends
        run_beat(16'h0001, rand_beat(), 0);
        run_beat(16'h8000, rand_beat(), 2);
        // Enable changes mid-beat must not affect captured mask
        run_beat(16'hFFFF, rand_beat(), 3);

        // Reset after the second word of a full beat
        for (int i = 0; i < 16; i++) beat[32*i +: 32] = 32'(i + 1);
        rx_valid = 1'b1;
        rx_data  = beat;
        enable   = 16'hFFFF;
        tx_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_val("mid_rst_word0", 64'(tx_data), 64'd1);
        @(negedge clk);
        check_val("mid_rst_word1", 64'(tx_data), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check_val("mid_rst_tx_last", 64'(tx_last), 64'd0);
        check_val("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ready_back", 64'(rx_ready), 64'd1);
        run_beat(16'hFFFF, rand_beat(), 0);

        // Random beats with random backpressure
        for (int n = 0; n < 40; n++) begin
            logic [15:0] m;
            m = (n % 8 == 7) ? 16'h0000 : 16'($urandom);
            run_beat(m, rand_beat(), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
